// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for the 18-bit CPU datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and
// keeps a wrapping retired-instruction counter for debug.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// INIT   0  | post-reset idle, all controls low, goes to FETCH
// FETCH  1  | read memory at PC; on MemReady load IR and PC <= PC+1
// DECODE 2  | JUMP retires here, illegal opcodes flagged and dropped
// EXECUTE 3 | ALU operation; BEQ resolves and retires here
// MEM    4  | LD/ST memory access at ALU result; ST retires on MemReady
// WRITEBACK5| register-file write of ALU result or load data
module control_unit #(
  parameter int COUNT_W = 16
) (
  input  logic               C,
  input  logic               Reset,
  input  logic [17:0]        Instruction,
  input  logic               Zero,
  input  logic               MemReady,
  output logic [1:0]         ALUControl,
  output logic               ALUSrcB,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               AddrSel,
  output logic               RegWrite,
  output logic               MemToReg,
  output logic               IllegalOp,
  output logic [2:0]         State,
  output logic [COUNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_ANDI = 4'b0101;
  localparam logic [3:0] OP_LD   = 4'b0110;
  localparam logic [3:0] OP_ST   = 4'b0111;
  localparam logic [3:0] OP_JUMP = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1001;

  state_t     state;
  state_t     state_next;
  logic       retire;
  logic [3:0] op;
  logic       unused_fields;

  assign op = Instruction[17:14];
  // Operand fields are consumed by the datapath; only the opcode matters here.
  assign unused_fields = ^Instruction[13:0];
  assign State = state;

  // State register; reset forces INIT immediately.
  always_ff @(posedge C or posedge Reset) begin
    if (Reset) state <= S_INIT;
    else       state <= state_next;
  end

  // Retired-instruction counter, advances on the edge leaving the retiring state.
  always_ff @(posedge C or posedge Reset) begin
    if (Reset)       InstrCount <= '0;
    else if (retire) InstrCount <= InstrCount + COUNT_W'(1);
  end

  // Next-state and control decode from state, opcode, MemReady and Zero.
  always_comb begin
    state_next = S_INIT;
    retire     = 1'b0;
    ALUControl = 2'b00;
    ALUSrcB    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 2'b00;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    AddrSel    = 1'b0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    IllegalOp  = 1'b0;
    case (state)
      S_INIT: state_next = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (op == OP_JUMP) begin
          PCWrite    = 1'b1;
          PCSrc      = 2'b10;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (op[3] && (op[2] || op[1])) begin
          IllegalOp  = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_next = S_WRITEBACK;
        if (op[3:2] == 2'b00) begin
          ALUControl = op[1:0];
        end else if (op == OP_ADDI) begin
          ALUSrcB    = 1'b1;
          ALUControl = 2'b01;
        end else if (op == OP_ANDI) begin
          ALUSrcB    = 1'b1;
        end else if (op == OP_LD || op == OP_ST) begin
          ALUSrcB    = 1'b1;
          ALUControl = 2'b01;
          state_next = S_MEM;
        end else if (op == OP_BEQ) begin
          PCSrc      = 2'b01;
          PCWrite    = Zero;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          // Instruction changed underneath us; abandon it without retiring.
          state_next = S_FETCH;
        end
      end
      S_MEM: begin
        AddrSel  = 1'b1;
        MemRead  = (op == OP_LD);
        MemWrite = (op == OP_ST);
        if (!MemReady) begin
          state_next = S_MEM;
        end else if (op == OP_LD) begin
          state_next = S_WRITEBACK;
        end else begin
          retire     = (op == OP_ST);
          state_next = S_FETCH;
        end
      end
      S_WRITEBACK: begin
        RegWrite   = 1'b1;
        MemToReg   = (op == OP_LD);
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_INIT;
    endcase
  end

endmodule
